// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-side ring ports and the memory controller's
// reply-state decoding.
//   ST_*      : 2-bit port FSM encodings reported on fsm_state_out.
//   FLIT_*    : flit type codes carried with each 16-bit flit.
//   MIN_IDX / MAX_IDX : legal range of the last-flit index of a message.
//   clamp_idx : saturates a requested last-flit index into the legal range.
package mem_port_pkg;

    localparam int FLIT_W  = 16;
    localparam int MAX_IDX = 10;
    localparam int MIN_IDX = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10
    } port_state_e;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    function automatic logic [3:0] clamp_idx(input logic [3:0] idx);
        if (idx < 4'(MIN_IDX)) begin
            return 4'(MIN_IDX);
        end else if (idx > 4'(MAX_IDX)) begin
            return 4'(MAX_IDX);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_rep_out_port_if.sv
// Flit handshake between a memory-side OUT port and the ring router.
//   v_flit_out    : flit_out/flit_ctrl_out are valid
//   flit_out      : current 16-bit flit
//   flit_ctrl_out : flit type (head/body/tail)
//   ack_in        : router accepted the presented flit this cycle
// master = port side, slave = router side.
interface mem_rep_out_port_if;
    import mem_port_pkg::*;

    logic              v_flit_out;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        flit_ctrl_out;
    logic              ack_in;

    modport master (output v_flit_out, output flit_out, output flit_ctrl_out, input ack_in);
    modport slave  (input v_flit_out, input flit_out, input flit_ctrl_out, output ack_in);

endinterface

// File: rtl/mem_rep_out_port.sv
// Memory-side OUT reply port. Captures one reply (head, addr, data and its
// last-flit index) from the memory controller and serialises it into 16-bit
// flits toward the ring router.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   en_flit_max_in     : load strobe for flit_max_in
//   flit_max_in[3:0]   : last-flit index for the next captured message
//   v_rep_in           : reply valid / capture strobe
//   head_in, addr_in, data_in : reply contents
//   rtr                : flit handshake to the router (master side)
//   fsm_state_out[1:0] : port state, decoded by the controller
//   overrun_err        : sticky, a reply arrived while the port was busy
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no message held; v_rep_in captures a new one
// ST_HEAD | presenting the head flit (index 0) until acked
// ST_BODY | presenting flit[cnt]; tail when cnt equals the latched max
module mem_rep_out_port
    import mem_port_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en_flit_max_in,
    input  logic [3:0]    flit_max_in,
    input  logic          v_rep_in,
    input  logic [15:0]   head_in,
    input  logic [31:0]   addr_in,
    input  logic [127:0]  data_in,
    mem_rep_out_port_if.master rtr,
    output logic [1:0]    fsm_state_out,
    output logic          overrun_err
);

    port_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  fmax_prog_q;
    logic [3:0]  fmax_msg_q;
    // Element MAX_IDX holds the head so that flit index i sits at MAX_IDX - i.
    logic [MAX_IDX:0][FLIT_W-1:0] msg_q;
    logic              capture;
    logic              is_tail;
    logic [FLIT_W-1:0] cur_flit;

    assign capture  = (state_q == ST_IDLE) && v_rep_in;
    assign is_tail  = (cnt_q == fmax_msg_q);
    assign cur_flit = msg_q[4'(MAX_IDX) - cnt_q];

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        rtr.v_flit_out    = 1'b0;
        rtr.flit_out      = '0;
        rtr.flit_ctrl_out = FLIT_BODY;
        case (state_q)
            ST_IDLE: begin
                if (v_rep_in) begin
                    state_d = ST_HEAD;
                    cnt_d   = 4'd0;
                end
            end
            ST_HEAD: begin
                rtr.v_flit_out    = 1'b1;
                rtr.flit_out      = cur_flit;
                rtr.flit_ctrl_out = FLIT_HEAD;
                if (rtr.ack_in) begin
                    state_d = ST_BODY;
                    cnt_d   = 4'd1;
                end
            end
            ST_BODY: begin
                rtr.v_flit_out    = 1'b1;
                rtr.flit_out      = cur_flit;
                rtr.flit_ctrl_out = is_tail ? FLIT_TAIL : FLIT_BODY;
                if (rtr.ack_in) begin
                    if (is_tail) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fmax_prog_q <= 4'(MIN_IDX);
            fmax_msg_q  <= 4'(MIN_IDX);
            msg_q       <= '0;
            overrun_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (en_flit_max_in) begin
                fmax_prog_q <= clamp_idx(flit_max_in);
            end
            if (capture) begin
                msg_q      <= {head_in, addr_in, data_in};
                // A load coinciding with the capture applies to this message.
                fmax_msg_q <= en_flit_max_in ? clamp_idx(flit_max_in) : fmax_prog_q;
            end
            // Includes the tail-ack cycle: the port is still busy there.
            if (v_rep_in && (state_q != ST_IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

    assign fsm_state_out = state_q;

endmodule

// File: tb/tb_mem_rep_out_port.sv
module tb_mem_rep_out_port;
    import mem_port_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en_flit_max_in = 1'b0;
    logic [3:0]   flit_max_in = '0;
    logic         v_rep_in = 1'b0;
    logic [15:0]  head_in = '0;
    logic [31:0]  addr_in = '0;
    logic [127:0] data_in = '0;
    logic [1:0]   fsm_state_out;
    logic         overrun_err;

    mem_rep_out_port_if rtr();

    mem_rep_out_port dut (
        .clk            (clk),
        .rst            (rst),
        .en_flit_max_in (en_flit_max_in),
        .flit_max_in    (flit_max_in),
        .v_rep_in       (v_rep_in),
        .head_in        (head_in),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .rtr            (rtr),
        .fsm_state_out  (fsm_state_out),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: programmed last-flit index and expected message.
    int          model_fmax = 2;
    logic [15:0] exp_flit [0:10];
    logic [1:0]  exp_ctrl [0:10];
    int          exp_n;

    // Observed accepted flits of the last message.
    logic [15:0] obs_flit  [0:15];
    logic [1:0]  obs_ctrl  [0:15];
    logic [1:0]  obs_state [0:15];
    int          obs_n, stab_viol, busy_cycles;
    logic        first_valid, post_v, timed_out;
    logic [1:0]  post_state;

    function automatic int clamp_model(input int v);
        return (v < 2) ? 2 : ((v > 10) ? 10 : v);
    endfunction

    task automatic build_expected(input logic [15:0] h, input logic [31:0] a,
                                  input logic [127:0] d, input int mx);
        exp_n = mx + 1;
        for (int i = 0; i <= mx; i++) begin
            if (i == 0)     exp_flit[i] = h;
            else if (i < 3) exp_flit[i] = 16'(a >> (16 * (2 - i)));
            else            exp_flit[i] = 16'(d >> (16 * (10 - i)));
            exp_ctrl[i] = (i == 0) ? 2'b01 : ((i == mx) ? 2'b10 : 2'b00);
        end
    endtask

    // ack_mode: 0 = always, 1 = alternate starting high, 2 = random.
    task automatic send_collect(input logic [15:0] h, input logic [31:0] a,
                                input logic [127:0] d, input bit load,
                                input logic [3:0] fm, input int ack_mode,
                                input int inject_at, input int midload_at,
                                input logic [3:0] midload_val);
        int          cyc;
        bit          held, ack;
        logic [15:0] pf;
        logic [1:0]  pc;
        head_in = h; addr_in = a; data_in = d;
        v_rep_in = 1'b1; en_flit_max_in = load; flit_max_in = fm;
        rtr.ack_in = (ack_mode == 0);
        if (load) model_fmax = clamp_model(int'(fm));
        build_expected(h, a, d, model_fmax);
        @(posedge clk); #1;
        v_rep_in = 1'b0; en_flit_max_in = 1'b0;
        head_in = ~h; addr_in = $urandom; data_in = {$urandom, $urandom, $urandom, $urandom};
        first_valid = rtr.v_flit_out;
        obs_n = 0; stab_viol = 0; busy_cycles = 0; held = 0; timed_out = 0;
        pf = '0; pc = '0;
        cyc = 0;
        while (1) begin
            if (cyc >= 200) begin timed_out = 1; break; end
            if (!rtr.v_flit_out) break;
            busy_cycles++;
            if (held && (rtr.flit_out !== pf || rtr.flit_ctrl_out !== pc)) stab_viol++;
            ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            rtr.ack_in = ack;
            v_rep_in = (cyc == inject_at);
            if (cyc == midload_at) begin
                en_flit_max_in = 1'b1; flit_max_in = midload_val;
                model_fmax = clamp_model(int'(midload_val));
            end else begin
                en_flit_max_in = 1'b0;
            end
            if (ack) begin
                if (obs_n < 16) begin
                    obs_flit[obs_n]  = rtr.flit_out;
                    obs_ctrl[obs_n]  = rtr.flit_ctrl_out;
                    obs_state[obs_n] = fsm_state_out;
                end
                obs_n++;
                held = 0;
            end else begin
                held = 1; pf = rtr.flit_out; pc = rtr.flit_ctrl_out;
            end
            @(posedge clk); #1;
            cyc++;
        end
        v_rep_in = 1'b0; en_flit_max_in = 1'b0; rtr.ack_in = 1'b0;
        post_v = rtr.v_flit_out; post_state = fsm_state_out;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (rtr.v_flit_out !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", rtr.v_flit_out); end
        n_checks++; if (rtr.flit_out !== 16'h0) begin n_fail++; $display("FAIL reset_flit: got %h want 0000", rtr.flit_out); end
        n_checks++; if (rtr.flit_ctrl_out !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00", rtr.flit_ctrl_out); end
        n_checks++; if (fsm_state_out !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", fsm_state_out); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_err); end
        @(posedge clk); #1 rst = 1'b1;
        rtr.ack_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (fsm_state_out !== 2'b00 || rtr.v_flit_out !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: state %b v %b want 00 0", fsm_state_out, rtr.v_flit_out); end
        rtr.ack_in = 1'b0;
    endtask

    task automatic test_basic();
        send_collect(16'hA001, 32'h1234_5678, '0, 1'b1, 4'd2, 0, -1, -1, 4'd0);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
        n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid: got %b want 1", first_valid); end
        n_checks++; if (obs_n !== 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", obs_n); end
        n_checks++; if (busy_cycles !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", busy_cycles); end
        for (int i = 0; i < 3 && i < obs_n; i++) begin
            n_checks++;
            if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i] || obs_state[i] !== ((i == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL basic_flit%0d: got %h/%b/%b want %h/%b/%b", i, obs_flit[i], obs_ctrl[i], obs_state[i],
                         exp_flit[i], exp_ctrl[i], (i == 0) ? 2'b01 : 2'b10);
            end
        end
        n_checks++; if (post_v !== 1'b0 || post_state !== 2'b00) begin
            n_fail++; $display("FAIL basic_end: v %b state %b want 0 00", post_v, post_state); end
    endtask

    task automatic test_toggle_ack();
        send_collect(16'hB00B, 32'hCAFE_F00D, 128'h0001_0002_0003_0004_0005_0006_0007_0008,
                     1'b1, 4'd10, 1, -1, -1, 4'd0);
        n_checks++; if (obs_n !== 11) begin n_fail++; $display("FAIL toggle_count: got %0d want 11", obs_n); end
        n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL toggle_stable: got %0d changes want 0", stab_viol); end
        for (int i = 0; i < 11 && i < obs_n; i++) begin
            n_checks++;
            if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i]) begin
                n_fail++; $display("FAIL toggle_flit%0d: got %h/%b want %h/%b", i, obs_flit[i], obs_ctrl[i], exp_flit[i], exp_ctrl[i]);
            end
        end
        n_checks++; if (obs_flit[10] !== 16'h0008 || obs_ctrl[10] !== 2'b10) begin
            n_fail++; $display("FAIL toggle_tail: got %h/%b want 0008/10", obs_flit[10], obs_ctrl[10]); end
    endtask

    task automatic test_overrun();
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b want 0", overrun_err); end
        send_collect(16'hC0DE, 32'h0BAD_BEEF, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd10, 0, 4, -1, 4'd0);
        n_checks++; if (obs_n !== 11) begin n_fail++; $display("FAIL overrun_count: got %0d want 11", obs_n); end
        for (int i = 0; i < 11 && i < obs_n; i++) begin
            n_checks++;
            if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i]) begin
                n_fail++; $display("FAIL overrun_flit%0d: got %h/%b want %h/%b", i, obs_flit[i], obs_ctrl[i], exp_flit[i], exp_ctrl[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rtr.v_flit_out !== 1'b0 || fsm_state_out !== 2'b00) begin
            n_fail++; $display("FAIL overrun_dropped: v %b state %b want 0 00", rtr.v_flit_out, fsm_state_out); end
        n_checks++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun_err); end
    endtask

    task automatic test_clamp();
        send_collect(16'h1111, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'hF, 0, -1, -1, 4'd0);
        n_checks++; if (obs_n !== 11) begin n_fail++; $display("FAIL clamp_high: got %0d flits want 11", obs_n); end
        send_collect(16'h2222, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'h0, 0, -1, -1, 4'd0);
        n_checks++; if (obs_n !== 3) begin n_fail++; $display("FAIL clamp_low: got %0d flits want 3", obs_n); end
        // Preload in IDLE, then send without a load.
        en_flit_max_in = 1'b1; flit_max_in = 4'd7; model_fmax = clamp_model(7);
        @(posedge clk); #1 en_flit_max_in = 1'b0;
        // In-flight load must only affect the following message.
        send_collect(16'h3333, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0, 2, -1, 2, 4'd3);
        n_checks++; if (obs_n !== exp_n || exp_n !== 8) begin n_fail++; $display("FAIL preload: got %0d flits want 8", obs_n); end
        for (int i = 0; i < exp_n && i < obs_n; i++) begin
            n_checks++;
            if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i]) begin
                n_fail++; $display("FAIL preload_flit%0d: got %h/%b want %h/%b", i, obs_flit[i], obs_ctrl[i], exp_flit[i], exp_ctrl[i]);
            end
        end
        send_collect(16'h4444, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0, 0, -1, -1, 4'd0);
        n_checks++; if (obs_n !== 4) begin n_fail++; $display("FAIL midload_next: got %0d flits want 4", obs_n); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        head_in = 16'h5555; addr_in = $urandom; data_in = d;
        v_rep_in = 1'b1; en_flit_max_in = 1'b1; flit_max_in = 4'd10; rtr.ack_in = 1'b1;
        model_fmax = 10;
        build_expected(head_in, addr_in, d, 10);
        @(posedge clk); #1 v_rep_in = 1'b0; en_flit_max_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (rtr.flit_out !== exp_flit[5] || fsm_state_out !== 2'b10) begin
            n_fail++; $display("FAIL mid_flit5: got %h/%b want %h/10", rtr.flit_out, fsm_state_out, exp_flit[5]); end
        rst = 1'b0;
        #1;
        n_checks++; if (rtr.v_flit_out !== 1'b0 || fsm_state_out !== 2'b00 || rtr.flit_out !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset: v %b state %b flit %h want 0 00 0000", rtr.v_flit_out, fsm_state_out, rtr.flit_out); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: got %b want 0", overrun_err); end
        rtr.ack_in = 1'b0;
        model_fmax = 2;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rtr.v_flit_out !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume: got v %b want 0", rtr.v_flit_out); end
        send_collect(16'h6666, 32'h8765_4321, '0, 1'b0, 4'd0, 0, -1, -1, 4'd0);
        n_checks++; if (obs_n !== 3) begin n_fail++; $display("FAIL after_reset_count: got %0d want 3", obs_n); end
        for (int i = 0; i < 3 && i < obs_n; i++) begin
            n_checks++;
            if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i]) begin
                n_fail++; $display("FAIL after_reset_flit%0d: got %h/%b want %h/%b", i, obs_flit[i], obs_ctrl[i], exp_flit[i], exp_ctrl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        send_collect(16'h7001, $urandom, '0, 1'b1, 4'd2, 0, -1, -1, 4'd0);
        send_collect(16'h7002, 32'hAAAA_5555, '0, 1'b0, 4'd0, 0, -1, -1, 4'd0);
        n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", first_valid); end
        n_checks++; if (obs_n !== 3 || obs_flit[0] !== 16'h7002 || obs_flit[2] !== 16'h5555) begin
            n_fail++; $display("FAIL b2b_second: got n=%0d %h..%h want n=3 7002..5555", obs_n, obs_flit[0], obs_flit[2]); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", overrun_err); end
        // v_rep_in on the tail-ack cycle: rejected and flagged.
        send_collect(16'h7003, $urandom, '0, 1'b0, 4'd0, 0, 2, -1, 4'd0);
        n_checks++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL tail_ack_overrun: got %b want 1", overrun_err); end
        n_checks++; if (post_v !== 1'b0 || post_state !== 2'b00) begin
            n_fail++; $display("FAIL tail_ack_not_captured: v %b state %b want 0 00", post_v, post_state); end
    endtask

    task automatic test_random();
        for (int m = 0; m < 8; m++) begin
            send_collect(16'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom},
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2, -1,
                         int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            n_checks++; if (obs_n !== exp_n || timed_out !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d (timeout %b) want %0d", m, obs_n, timed_out, exp_n); end
            n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes want 0", m, stab_viol); end
            for (int i = 0; i < exp_n && i < obs_n; i++) begin
                n_checks++;
                if (obs_flit[i] !== exp_flit[i] || obs_ctrl[i] !== exp_ctrl[i]) begin
                    n_fail++; $display("FAIL rand%0d_flit%0d: got %h/%b want %h/%b", m, i, obs_flit[i], obs_ctrl[i], exp_flit[i], exp_ctrl[i]);
                end
            end
        end
    endtask

    initial begin
        rtr.ack_in = 1'b0;
        test_reset();
        test_basic();
        test_toggle_ack();
        test_overrun();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_rep_out_port.md
Name: mem_rep_out_port

Overview:
- Memory-side OUT reply port: the receiving end of the memory controller's "to OUT rep fifo" interface.
- Captures one reply message: head 16b, addr 32b, optional data 128b, plus the last-flit index. Serialises it into 16-bit flits toward the ring router with a valid/ack handshake.
- Reports its 2-bit FSM state back to the memory controller, which uses it as m_rep_fsm_state to decide when a new reply may be issued.

Parameters:
- FLIT_W, 16, flit width in bits. Fixed; head/addr/data slicing assumes 16.
- MAX_IDX, 10, highest legal flit index (head + 2 addr + 8 data flits).
- MIN_IDX, 2, lowest legal flit index (head + 2 addr flits, no data).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en_flit_max_in  in  1  load strobe for flit_max_in.
- flit_max_in  in  4  index of the last flit of the next message.
- v_rep_in  in  1  message valid; capture strobe.
- head_in  in  16  reply head flit.
- addr_in  in  32  reply address.
- data_in  in  128  reply data line.
- ack_in  in  1  router accepted the presented flit this cycle.
- v_flit_out  out  1  flit_out is valid.
- flit_out  out  16  current flit.
- flit_ctrl_out  out  2  flit type: 01 head, 00 body, 10 tail.
- fsm_state_out  out  2  00 IDLE, 01 HEAD, 10 BODY; 11 never driven.
- overrun_err  out  1  sticky flag: v_rep_in arrived while not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; flit counter 0; message register 0.
  - Programmed flit_max = MIN_IDX.
  - v_flit_out=0, flit_out=0, flit_ctrl_out=00, fsm_state_out=00, overrun_err=0.
  - Reset mid-transmission discards the message; no further flits are presented.
- flit_max register:
  - Loads on en_flit_max_in in any state. A load takes effect for the next captured message only; the message in flight keeps its latched index.
  - Values <MIN_IDX are stored as MIN_IDX; values >MAX_IDX are stored as MAX_IDX.
  - If en_flit_max_in and v_rep_in coincide in IDLE, the new value applies to that message.
- Capture (IDLE and v_rep_in=1):
  - Latch head/addr/data and the effective flit_max; counter=0; next state HEAD.
  - First flit is presented one cycle after the capture strobe.
- Flit order:
  - idx0 = head.
  - idx1 = addr[31:16]; idx2 = addr[15:0].
  - idx3..10 = data[127:112] down to data[15:0].
- HEAD state:
  - v_flit_out=1, flit_ctrl_out=01, flit_out=head.
  - Hold the flit until ack_in; on ack, counter=1 and go to BODY.
- BODY state:
  - v_flit_out=1, flit_out=flit[counter].
  - flit_ctrl_out=10 when counter==latched max, else 00.
  - On ack with counter<max: counter+1.
  - On ack with counter==max: go to IDLE, v_flit_out=0 next cycle.
- Handshake:
  - Flit data and ctrl stay stable while v_flit_out=1 and ack_in=0.
  - ack_in while v_flit_out=0 is ignored.
  - At most one flit per cycle.
- Back-to-back: a v_rep_in in the cycle IDLE is re-entered is captured. v_rep_in in the same cycle as the tail ack is not captured.
- Overrun: v_rep_in while in HEAD or BODY is dropped and sets overrun_err. The in-flight message is unaffected. overrun_err clears only on reset.
- Latency: minimum occupancy = 1 + (max+1) cycles with ack held high. That is 4 cycles for a 3-flit reply and 12 cycles for an 11-flit reply.
- Message register is a flit-indexed mux (or a left shift by 16 per ack); either is acceptable if the outputs match.

Decomposition:
- Shared package (mem_port_pkg):
  - state encodings ST_IDLE=2'b00, ST_HEAD=2'b01, ST_BODY=2'b10.
  - flit ctrl codes FLIT_HEAD=2'b01, FLIT_BODY=2'b00, FLIT_TAIL=2'b10.
  - MIN_IDX and MAX_IDX.
  - Reused by the req-side port and by the memory controller's state decoding.
- No sub-module; FSM, counter and message register sit in one module.

Test Plan:
- Reset, then v_rep_in with head=16'hA001, addr=32'h1234_5678, flit_max=2, ack tied 1 -> flits A001(01), 1234(00), 5678(10) on consecutive cycles. fsm_state 01,10,10, then 00.
- flit_max=10, data=128'h0001_0002_…_0008, ack toggling 1/0 -> 11 flits in order ending 0008 with ctrl 10. Each flit held stable through ack=0 cycles.
- v_rep_in during BODY with a different head -> second message never appears; overrun_err=1 and stays 1 after IDLE returns; first message completes intact.
- en_flit_max_in with 4'hF, then a message -> 11 flits (clamped to 10). en_flit_max_in with 0 -> 3 flits.
- rst asserted while at counter=5 in BODY -> same cycle v_flit_out=0 and fsm_state=00. After release, a new 3-flit message transmits correctly.
- Back-to-back: second v_rep_in in the first IDLE cycle after a tail ack -> head of the second message presented next cycle; a v_rep_in on the tail-ack cycle itself sets overrun_err.
